// File: rtl/ex_muldiv.sv
// Multi-cycle multiply / multiply-accumulate / divide engine for the EX stage.
// Result is {hi, lo}; for divides hi holds the remainder and lo the quotient.
module ex_muldiv #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_STAGES = 2,
  parameter int unsigned DIV_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 start,
  input  logic [2:0]           mode,
  input  logic                 stall_in,
  input  logic [WIDTH-1:0]     reg1,
  input  logic [WIDTH-1:0]     reg2,
  input  logic [2*WIDTH-1:0]   hilo,
  output logic [2*WIDTH-1:0]   ret,
  output logic                 done,
  output logic                 is_busy
);

  localparam int unsigned W2        = 2 * WIDTH;
  localparam int unsigned DIV_STEPS = WIDTH / DIV_BITS;
  localparam int unsigned CNT_W     = ($clog2(DIV_STEPS) > 2) ? $clog2(DIV_STEPS) : 2;
  localparam int unsigned MUL_LOAD  = (MUL_STAGES > 1) ? MUL_STAGES - 2 : 0;
  localparam int unsigned DIV_LOAD  = (DIV_STEPS > 1) ? DIV_STEPS - 2 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_ACC,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               acc_q;
  logic               sub_q;
  logic [W2-1:0]      hilo_q;
  logic [W2-1:0]      prod_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   dvs_q;
  logic               q_neg_q;
  logic               r_neg_q;

  // Decode of the live request, only meaningful in the start cycle
  logic               live_signed;
  logic               live_div;
  logic               live_acc;
  logic               live_sub;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [W2-1:0]      ext_a;
  logic [W2-1:0]      ext_b;
  logic [W2-1:0]      prod_live;

  always_comb begin
    live_signed = ~mode[0];
    live_div    = mode[2] & mode[1];
    live_acc    = mode[2] ^ mode[1];
    live_sub    = mode[2] & ~mode[1];
    a_neg       = live_signed & reg1[WIDTH-1];
    b_neg       = live_signed & reg2[WIDTH-1];
    a_mag       = a_neg ? (WIDTH'(0) - reg1) : reg1;
    b_mag       = b_neg ? (WIDTH'(0) - reg2) : reg2;
    ext_a       = {{WIDTH{a_neg}}, reg1};
    ext_b       = {{WIDTH{b_neg}}, reg2};
    prod_live   = ext_a * ext_b;
  end

  // Restoring divide step: retires DIV_BITS quotient bits per cycle
  logic [WIDTH-1:0]   step_rem;
  logic [WIDTH-1:0]   step_quo;
  logic [WIDTH:0]     trial;

  always_comb begin
    step_rem = rem_q;
    step_quo = quo_q;
    trial    = '0;
    for (int unsigned i = 0; i < DIV_BITS; i++) begin
      trial    = {step_rem, step_quo[WIDTH-1]};
      step_quo = {step_quo[WIDTH-2:0], 1'b0};
      if (trial >= {1'b0, dvs_q}) begin
        trial       = trial - {1'b0, dvs_q};
        step_quo[0] = 1'b1;
      end
      step_rem = trial[WIDTH-1:0];
    end
  end

  logic [WIDTH-1:0]   fix_rem;
  logic [WIDTH-1:0]   fix_quo;

  always_comb begin
    fix_quo = q_neg_q ? (WIDTH'(0) - step_quo) : step_quo;
    fix_rem = r_neg_q ? (WIDTH'(0) - step_rem) : step_rem;
  end

  // Stall request: raised in the accepting cycle, dropped on flush or once the result is up
  always_comb begin
    is_busy = 1'b0;
    if (!rst && !flush) begin
      case (state)
        S_IDLE:  is_busy = start;
        S_DONE:  is_busy = 1'b0;
        default: is_busy = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      acc_q   <= 1'b0;
      sub_q   <= 1'b0;
      hilo_q  <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      ret     <= '0;
      done    <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc_q   <= live_acc;
            sub_q   <= live_sub;
            hilo_q  <= hilo;
            prod_q  <= prod_live;
            rem_q   <= '0;
            quo_q   <= a_mag;
            dvs_q   <= b_mag;
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
            if (live_div) begin
              if (reg2 == '0) begin
                ret   <= {reg1, {WIDTH{1'b1}}};
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                cnt   <= CNT_W'(DIV_LOAD);
                state <= (DIV_STEPS > 1) ? S_DIV : S_FIX;
              end
            end else if (MUL_STAGES > 1) begin
              cnt   <= CNT_W'(MUL_LOAD);
              state <= S_MUL;
            end else if (live_acc) begin
              state <= S_ACC;
            end else begin
              ret   <= prod_live;
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_MUL: begin
          if (cnt == '0) begin
            if (acc_q) begin
              state <= S_ACC;
            end else begin
              ret   <= prod_q;
              done  <= 1'b1;
              state <= S_DONE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_ACC: begin
          ret   <= sub_q ? (hilo_q - prod_q) : (hilo_q + prod_q);
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DIV: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          if (cnt == '0) begin
            state <= S_FIX;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        // Final quotient bits and sign correction share this cycle
        S_FIX: begin
          ret   <= {fix_rem, fix_quo};
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          if (!stall_in) begin
            done  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
